// File: rtl/lap_stopwatch_if.sv
// Button and display bundle for the lap stopwatch.
// Buttons are active-low; HEX outputs are active-low segments.
interface lap_stopwatch_if;
  logic       start_stop;
  logic       lap_reset;
  logic       recall;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic [6:0] HEX6;
  logic [6:0] HEX7;

  modport master (
    output start_stop, lap_reset, recall,
    input  HEX0, HEX1, HEX2, HEX3,
    input  HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  start_stop, lap_reset, recall,
    output HEX0, HEX1, HEX2, HEX3,
    output HEX4, HEX5, HEX6, HEX7
  );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD stopwatch (mm:ss.t) with circular lap buffer,
// recall browsing and registered 7-segment outputs.
module lap_stopwatch #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 10,
  parameter int NUM_LAPS = 8
) (
  input logic            clk,
  input logic            rstn,
  lap_stopwatch_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int IW  = (NUM_LAPS > 1) ? $clog2(NUM_LAPS) : 1;
  localparam logic [6:0] NL        = 7'(NUM_LAPS);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, RECALL
  } state_t;

  typedef struct packed {
    logic [2:0] m1;
    logic [3:0] m0;
    logic [2:0] s1;
    logic [3:0] s0;
    logic [3:0] t0;
  } bcd_t;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  logic ss_q, lr_q, rc_q;
  logic ev_ss, ev_lr, ev_rc;

  // Press events are registered, so they act one cycle later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ss_q  <= 1'b1;
      lr_q  <= 1'b1;
      rc_q  <= 1'b1;
      ev_ss <= 1'b0;
      ev_lr <= 1'b0;
      ev_rc <= 1'b0;
    end else begin
      ss_q  <= bus.start_stop;
      lr_q  <= bus.lap_reset;
      rc_q  <= bus.recall;
      ev_ss <= ss_q & ~bus.start_stop;
      ev_lr <= lr_q & ~bus.lap_reset;
      ev_rc <= rc_q & ~bus.recall;
    end
  end

  state_t        state_q, state_d;
  state_t        ret_q, ret_d;
  logic [6:0]    sel_q, sel_d;
  logic [6:0]    cnt_q;
  logic [IW-1:0] wp_q;
  logic [DW-1:0] div_q;
  bcd_t          tm_q, tm_inc, lap_rd, shown;
  bcd_t          lap_mem [0:(2**IW)-1];
  logic          do_lap, do_clear, tick, run_entry;
  logic [7:0]    rd_sum;
  logic [IW-1:0] rd_idx;
  logic [3:0]    sel_t, sel_u;
  logic [7:0][6:0] hex_d, hex_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      sel_q   <= 7'd1;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      sel_q   <= sel_d;
    end
  end

  // Event priority: start_stop, then lap_reset, then recall.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    sel_d    = sel_q;
    do_lap   = 1'b0;
    do_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_ss) begin
          state_d = RUN;
        end else if (ev_lr) begin
          state_d = IDLE;
        end else if (ev_rc && cnt_q != 7'd0) begin
          state_d = RECALL;
          ret_d   = IDLE;
          sel_d   = 7'd1;
        end
      end
      RUN: begin
        if (ev_ss) begin
          state_d = PAUSE;
        end else if (ev_lr) begin
          do_lap = 1'b1;
        end
      end
      PAUSE: begin
        if (ev_ss) begin
          state_d = RUN;
        end else if (ev_lr) begin
          state_d  = IDLE;
          do_clear = 1'b1;
          sel_d    = 7'd1;
        end else if (ev_rc && cnt_q != 7'd0) begin
          state_d = RECALL;
          ret_d   = PAUSE;
          sel_d   = 7'd1;
        end
      end
      RECALL: begin
        if (ev_ss) begin
          sel_d = (sel_q >= cnt_q) ? 7'd1 : sel_q + 7'd1;
        end else if (ev_lr || ev_rc) begin
          state_d = ret_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick      = (state_q == RUN) && (div_q == DW'(DIV - 1));
  assign run_entry = (state_d == RUN) && (state_q != RUN);

  always_comb begin
    tm_inc = tm_q;
    if (tm_q.t0 != 4'd9) begin
      tm_inc.t0 = tm_q.t0 + 4'd1;
    end else begin
      tm_inc.t0 = 4'd0;
      if (tm_q.s0 != 4'd9) begin
        tm_inc.s0 = tm_q.s0 + 4'd1;
      end else begin
        tm_inc.s0 = 4'd0;
        if (tm_q.s1 != 3'd5) begin
          tm_inc.s1 = tm_q.s1 + 3'd1;
        end else begin
          tm_inc.s1 = 3'd0;
          if (tm_q.m0 != 4'd9) begin
            tm_inc.m0 = tm_q.m0 + 4'd1;
          end else begin
            tm_inc.m0 = 4'd0;
            tm_inc.m1 = (tm_q.m1 == 3'd5) ? 3'd0 : tm_q.m1 + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_q <= '0;
      tm_q  <= '0;
      wp_q  <= '0;
      cnt_q <= 7'd0;
    end else begin
      if (run_entry) begin
        div_q <= '0;
      end else if (state_q == RUN) begin
        div_q <= tick ? '0 : div_q + DW'(1);
      end
      if (do_clear) begin
        tm_q <= '0;
      end else if (tick) begin
        tm_q <= tm_inc;
      end
      if (do_clear) begin
        wp_q  <= '0;
        cnt_q <= 7'd0;
      end else if (do_lap) begin
        wp_q <= (wp_q == IW'(NUM_LAPS - 1)) ? '0 : wp_q + IW'(1);
        if (cnt_q != NL) cnt_q <= cnt_q + 7'd1;
      end
    end
  end

  // tm_q is the pre-increment value even on a tick cycle.
  always_ff @(posedge clk) begin
    if (rstn && do_lap) lap_mem[wp_q] <= tm_q;
  end

  // Slot 1 is the oldest retained lap: wp - cnt, modulo depth.
  always_comb begin
    rd_sum = {1'b0, 7'(wp_q)} + 8'(NUM_LAPS) - {1'b0, cnt_q}
           + {1'b0, sel_q} - 8'd1;
    if (rd_sum >= 8'(NUM_LAPS)) rd_sum = rd_sum - 8'(NUM_LAPS);
    rd_idx = rd_sum[IW-1:0];
  end

  assign lap_rd = lap_mem[rd_idx];
  assign sel_t  = 4'(sel_q / 7'd10);
  assign sel_u  = 4'(sel_q % 7'd10);

  always_comb begin
    shown    = (state_q == RECALL) ? lap_rd : tm_q;
    hex_d[0] = seg(shown.t0);
    hex_d[1] = seg(shown.s0);
    hex_d[2] = seg({1'b0, shown.s1});
    hex_d[3] = seg(shown.m0);
    hex_d[4] = seg({1'b0, shown.m1});
    hex_d[5] = SEG_BLANK;
    hex_d[6] = SEG_BLANK;
    hex_d[7] = SEG_BLANK;
    if (state_q == RECALL) begin
      hex_d[6] = seg(sel_u);
      hex_d[7] = seg(sel_t);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hex_q <= {{3{SEG_BLANK}}, {5{SEG_ZERO}}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];
  assign bus.HEX6 = hex_q[6];
  assign bus.HEX7 = hex_q[7];
endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: vector table, corner sequences
// and random buttons against a tenths-count reference model.
module tb_lap_stopwatch;
  localparam int CLK_HZ   = 20;
  localparam int TICK_HZ  = 10;
  localparam int NUM_LAPS = 4;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] Z  = 7'b1000000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  lap_stopwatch_if bus();

  lap_stopwatch #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .NUM_LAPS(NUM_LAPS)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_RECALL} mode_t;
  mode_t m_mode = M_IDLE;
  mode_t m_ret = M_IDLE;
  int m_t = 0;
  int m_runcyc = 0;
  int m_sel = 1;
  int m_laps[$];
  bit [2:0] m_prev = 3'b111;
  bit [2:0] m_ev = 3'b000;
  logic [7:0][6:0] m_hex;

  typedef struct {
    string      name;
    bit [2:0]   btn;
    int         wait_n;
    logic [6:0] e0;
    logic [6:0] e1;
    logic [6:0] e6;
  } vec_t;
  vec_t vt[4];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BL;
    endcase
  endfunction

  function automatic logic [7:0][6:0] view();
    logic [7:0][6:0] r;
    int v;
    v = (m_mode == M_RECALL) ? m_laps[m_sel-1] : m_t;
    r[0] = seg(v % 10);
    r[1] = seg((v / 10) % 10);
    r[2] = seg((v / 100) % 6);
    r[3] = seg((v / 600) % 10);
    r[4] = seg(v / 6000);
    r[5] = BL;
    r[6] = BL;
    r[7] = BL;
    if (m_mode == M_RECALL) begin
      r[6] = seg(m_sel % 10);
      r[7] = seg(m_sel / 10);
    end
    return r;
  endfunction

  task automatic model_edge();
    bit [2:0] cur;
    bit tick;
    cur = {bus.start_stop, bus.lap_reset, bus.recall};
    if (!rstn) begin
      m_mode = M_IDLE;
      m_ret = M_IDLE;
      m_t = 0;
      m_runcyc = 0;
      m_sel = 1;
      m_laps.delete();
      m_prev = 3'b111;
      m_ev = 3'b000;
      m_hex = {BL, BL, BL, Z, Z, Z, Z, Z};
      return;
    end
    m_hex = view();
    tick = (m_mode == M_RUN) && ((m_runcyc % DIV) == DIV - 1);
    if (m_mode == M_RUN) m_runcyc++;
    case (m_mode)
      M_IDLE: begin
        if (m_ev[2]) begin
          m_mode = M_RUN;
          m_runcyc = 0;
        end else if (!m_ev[1] && m_ev[0] && m_laps.size() > 0) begin
          m_ret = M_IDLE;
          m_mode = M_RECALL;
          m_sel = 1;
        end
      end
      M_RUN: begin
        if (m_ev[2]) begin
          m_mode = M_PAUSE;
        end else if (m_ev[1]) begin
          m_laps.push_back(m_t);
          if (m_laps.size() > NUM_LAPS) void'(m_laps.pop_front());
        end
      end
      M_PAUSE: begin
        if (m_ev[2]) begin
          m_mode = M_RUN;
          m_runcyc = 0;
        end else if (m_ev[1]) begin
          m_mode = M_IDLE;
          m_t = 0;
          m_sel = 1;
          m_laps.delete();
        end else if (m_ev[0] && m_laps.size() > 0) begin
          m_ret = M_PAUSE;
          m_mode = M_RECALL;
          m_sel = 1;
        end
      end
      default: begin
        if (m_ev[2]) begin
          m_sel = (m_sel >= m_laps.size()) ? 1 : m_sel + 1;
        end else if (m_ev[1] || m_ev[0]) begin
          m_mode = m_ret;
        end
      end
    endcase
    if (tick) m_t = (m_t + 1) % 36000;
    m_ev = m_prev & ~cur;
    m_prev = cur;
  endtask

  function automatic logic [7:0][6:0] dut_hex();
    return {bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4,
            bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  task automatic check_all(input string name);
    total++;
    if (dut_hex() !== m_hex) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h",
               name, $time, dut_hex(), m_hex);
    end
  endtask

  task automatic chk7(input string name, input logic [6:0] act,
                      input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=timeout required=reached", name);
    end
  endtask

  task automatic drive(input bit [2:0] lows);
    bus.start_stop = ~lows[2];
    bus.lap_reset  = ~lows[1];
    bus.recall     = ~lows[0];
  endtask

  task automatic step(input bit chk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk) check_all("cycle");
  endtask

  task automatic press(input bit [2:0] lows, input int wait_n);
    drive(lows);
    step(1'b1);
    drive(3'b000);
    repeat (wait_n) step(1'b1);
  endtask

  initial begin
    bit ok;
    int exp_sel[4];
    int exp_sec[4];
    int tgt;
    int r;
    bit [2:0] lows;

    vt[0] = '{"start_run",   3'b100, 20, 7'b0010000, Z, BL};
    vt[1] = '{"stop_hold",   3'b100, 10, Z, 7'b1111001, BL};
    vt[2] = '{"pause_clear", 3'b010, 3, Z, Z, BL};
    vt[3] = '{"idle_recall", 3'b001, 3, Z, Z, BL};
    exp_sel = '{2, 3, 4, 1};
    exp_sec = '{3, 4, 5, 2};

    drive(3'b000);
    rstn = 1'b0;
    repeat (3) step(1'b1);
    chk7("reset_hex0", bus.HEX0, Z);
    chk7("reset_hex4", bus.HEX4, Z);
    chk7("reset_hex5", bus.HEX5, BL);
    chk7("reset_hex7", bus.HEX7, BL);
    rstn = 1'b1;
    repeat (2) step(1'b1);

    for (int i = 0; i < 4; i++) begin
      press(vt[i].btn, vt[i].wait_n);
      chk7({vt[i].name, "_hex0"}, bus.HEX0, vt[i].e0);
      chk7({vt[i].name, "_hex1"}, bus.HEX1, vt[i].e1);
      chk7({vt[i].name, "_hex6"}, bus.HEX6, vt[i].e6);
    end

    // full-range wrap
    press(3'b100, 0);
    ok = 1'b0;
    for (int k = 0; k < 80000; k++) begin
      if (m_t == 35999) begin
        ok = 1'b1;
        break;
      end
      step(k % 97 == 0);
    end
    chk_ok("reach_59_59_9", ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      if (m_t == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk_ok("wrap_tick", ok);
    step(1'b1);
    chk7("wrap_hex0", bus.HEX0, Z);
    chk7("wrap_hex1", bus.HEX1, Z);
    chk7("wrap_hex2", bus.HEX2, Z);
    chk7("wrap_hex3", bus.HEX3, Z);
    chk7("wrap_hex4", bus.HEX4, Z);
    repeat (2) step(1'b1);
    chk7("wrap_still_run", bus.HEX0, 7'b1111001);

    rstn = 1'b0;
    step(1'b1);
    rstn = 1'b1;
    step(1'b1);

    // five laps into a four-deep buffer
    press(3'b100, 0);
    for (int l = 1; l <= 5; l++) begin
      tgt = 10 * l;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (m_t == tgt) begin
          ok = 1'b1;
          break;
        end
        step(1'b1);
      end
      chk_ok("lap_target", ok);
      press(3'b010, 0);
    end
    press(3'b100, 3);
    press(3'b001, 3);
    chk7("recall_sel1", bus.HEX6, 7'b1111001);
    chk7("recall_hex0", bus.HEX0, Z);
    chk7("recall_hex1", bus.HEX1, 7'b0100100);
    chk7("recall_hex2", bus.HEX2, Z);
    for (int i = 0; i < 4; i++) begin
      press(3'b100, 3);
      chk7("recall_sel", bus.HEX6, seg(exp_sel[i]));
      chk7("recall_lap", bus.HEX1, seg(exp_sec[i]));
    end
    press(3'b001, 3);
    chk7("recall_exit", bus.HEX6, BL);

    // start_stop beats lap_reset: no lap stored
    press(3'b100, 6);
    press(3'b110, 6);
    press(3'b001, 3);
    chk7("prio_oldest_s", bus.HEX1, 7'b0100100);
    chk7("prio_oldest_t", bus.HEX2, Z);
    press(3'b010, 3);

    press(3'b010, 3);
    press(3'b001, 3);
    chk7("clear_hex0", bus.HEX0, Z);
    chk7("clear_hex1", bus.HEX1, Z);
    chk7("clear_no_recall", bus.HEX6, BL);

    // held button yields a single start
    drive(3'b100);
    repeat (50) step(1'b1);
    chk7("hold_hex0", bus.HEX0, 7'b0110000);
    chk7("hold_hex1", bus.HEX1, 7'b0100100);
    drive(3'b100);
    rstn = 1'b0;
    step(1'b1);
    chk7("run_reset_hex0", bus.HEX0, Z);
    chk7("run_reset_hex1", bus.HEX1, Z);
    chk7("run_reset_hex6", bus.HEX6, BL);
    drive(3'b000);
    rstn = 1'b1;
    repeat (2) step(1'b1);

    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      lows = 3'b000;
      if (r < 6) lows[2] = 1'b1;
      else if (r < 12) lows[1] = 1'b1;
      else if (r < 17) lows[0] = 1'b1;
      else if (r == 17) lows = 3'b111;
      drive(lows);
      rstn = ($urandom_range(0, 299) != 0);
      step(1'b1);
    end
    rstn = 1'b1;
    drive(3'b000);
    step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
